dcmi_capture_packer: RTL

Front-end capture stage of the DCMI path: samples the camera's pixel clock, sync and 8-bit data lines, frames them with a small state machine, and packs bytes into 32-bit words. Each word is offered to the downstream ping-pong buffer through a single-entry holding register using that buffer's `wr_req`/`wr_rdy` handshake. Overruns are flagged rather than stalled, because the sensor cannot be back-pressured.

---
 rtl/dcmi_capture_packer_if.sv | 10 +
 rtl/dcmi_capture_packer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dcmi_capture_packer_if.sv
// Write-side handshake between the DCMI packer and the downstream ping-pong buffer.
// The master offers a 32-bit word with wr_req; the slave accepts it with wr_rdy.
interface dcmi_capture_packer_if;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        wr_rdy;

  modport master (output wr_req, output wr_data, input wr_rdy);
  modport slave  (input wr_req, input wr_data, output wr_rdy);
endinterface

// File: rtl/dcmi_capture_packer.sv
// DCMI front end: detects pixel-clock edges, frames vsync/hsync, packs bytes into 32-bit words
// and offers them through a single-entry holding register. Overruns set a sticky flag.
module dcmi_capture_packer #(
  parameter bit PCK_POL = 1'b1,
  parameter bit VS_POL  = 1'b1,
  parameter bit HS_POL  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         block_en,
  input  logic                         capture_mode,
  input  logic                         dcmi_pclk,
  input  logic                         dcmi_vsync,
  input  logic                         dcmi_hsync,
  input  logic [7:0]                   dcmi_data,
  dcmi_capture_packer_if.master        wr,
  output logic                         frame_done,
  output logic                         ovf,
  output logic [15:0]                  line_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_SYNC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            pclk_q;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] lanes_q, lanes_d;
  logic [15:0]     line_cnt_q, line_cnt_d;
  logic            hs_prev_q, hs_prev_d;
  logic            wr_req_q, wr_req_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic            ovf_q, ovf_d;
  logic            frame_done_q, frame_done_d;

  logic            smp;
  logic            vs_blank;
  logic            hs_act;
  logic [31:0]     flush_word;

  assign smp      = PCK_POL ? (dcmi_pclk & ~pclk_q) : (~dcmi_pclk & pclk_q);
  assign vs_blank = (dcmi_vsync == VS_POL);
  assign hs_act   = (dcmi_hsync == HS_POL);

  // Partial word at frame end: lanes at or above idx are forced to zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_flush
    assign flush_word[8*gi +: 8] = (2'(gi) < idx_q) ? lanes_q[gi] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q <= 1'b0;
    end else begin
      pclk_q <= dcmi_pclk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      lanes_q      <= '0;
      line_cnt_q   <= 16'h0000;
      hs_prev_q    <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_data_q    <= 32'h0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lanes_q      <= lanes_d;
      line_cnt_q   <= line_cnt_d;
      hs_prev_q    <= hs_prev_d;
      wr_req_q     <= wr_req_d;
      wr_data_q    <= wr_data_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
    end
  end

  logic        cap;
  logic [1:0]  cap_idx;
  logic [15:0] cap_line;
  logic        word_done;
  logic [31:0] word_val;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lanes_d      = lanes_q;
    line_cnt_d   = line_cnt_q;
    hs_prev_d    = hs_prev_q;
    wr_req_d     = wr_req_q;
    wr_data_d    = wr_data_q;
    ovf_d        = ovf_q;
    frame_done_d = 1'b0;
    cap          = 1'b0;
    cap_idx      = idx_q;
    cap_line     = line_cnt_q;
    word_done    = 1'b0;
    word_val     = 32'h0;

    if (smp) begin
      hs_prev_d = hs_act;
    end

    case (state_q)
      ST_IDLE: begin
        if (block_en) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (smp && vs_blank) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        // The frame-start sample is also a capture sample, starting from a clean index and count.
        if (smp && !vs_blank) begin
          state_d  = ST_CAPTURE;
          cap      = 1'b1;
          cap_idx  = 2'd0;
          cap_line = 16'h0000;
        end
      end
      ST_CAPTURE: begin
        if (smp) cap = 1'b1;
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (cap) begin
      idx_d      = cap_idx;
      line_cnt_d = cap_line;
      if (hs_prev_q && !hs_act && (cap_line != 16'hFFFF)) begin
        line_cnt_d = cap_line + 16'd1;
      end
      if (vs_blank) begin
        frame_done_d = 1'b1;
        state_d      = capture_mode ? ST_DONE : ST_SYNC;
        idx_d        = 2'd0;
        if (cap_idx != 2'd0) begin
          word_done = 1'b1;
          word_val  = flush_word;
        end
      end else if (hs_act) begin
        lanes_d[cap_idx] = dcmi_data;
        idx_d            = cap_idx + 2'd1;
        if (cap_idx == 2'd3) begin
          word_done = 1'b1;
          word_val  = {dcmi_data, lanes_q[2], lanes_q[1], lanes_q[0]};
        end
      end
    end

    // Holding register: load when empty or draining this cycle, otherwise drop and flag.
    if (word_done) begin
      if (!wr_req_q || wr.wr_rdy) begin
        wr_req_d  = 1'b1;
        wr_data_d = word_val;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (wr_req_q && wr.wr_rdy) begin
      wr_req_d = 1'b0;
    end

    if (!block_en) begin
      state_d      = ST_IDLE;
      idx_d        = 2'd0;
      lanes_d      = '0;
      line_cnt_d   = 16'h0000;
      hs_prev_d    = 1'b0;
      wr_req_d     = 1'b0;
      wr_data_d    = 32'h0;
      ovf_d        = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  assign wr.wr_req  = wr_req_q;
  assign wr.wr_data = wr_data_q;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;
  assign line_cnt   = line_cnt_q;

endmodule
